// File: rtl/block_ram_scan_serializer_if.sv
// Handshake/bus bundle between the RAM scan serializer, the RAM read ports
// and the serial sink. The serializer uses the master view; whatever drives
// start/rv/oready uses the slave view.
interface block_ram_scan_serializer_if #(
  parameter int ENTRY_NUM      = 4,
  parameter int ENTRY_BIT_SIZE = 4,
  parameter int READ_NUM       = 2
);
  localparam int INDEX_BIT_SIZE = $clog2(ENTRY_NUM);

  logic                      start;
  logic                      busy;
  logic                      done;
  logic [INDEX_BIT_SIZE-1:0] ra [READ_NUM];
  logic [ENTRY_BIT_SIZE-1:0] rv [READ_NUM];
  logic                      obit;
  logic                      ovalid;
  logic                      oready;

  modport master (
    input  start, rv, oready,
    output busy, done, ra, obit, ovalid
  );

  modport slave (
    output start, rv, oready,
    input  busy, done, ra, obit, ovalid
  );
endinterface

// File: rtl/block_ram_scan_serializer.sv
// Sweeps all RAM entries READ_NUM at a time and streams each group out
// LSB-first followed by one even-parity bit over a valid/ready link.
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_IDLE    | waiting for start, outputs quiet
// S_READ    | ra presents base..base+READ_NUM-1 to the RAM
// S_CAPTURE | ra held, RAM data arrives and is latched at the edge
// S_SHIFT   | group bits then parity bit offered on obit/ovalid
// S_DONE    | one-cycle done pulse, back to idle
module block_ram_scan_serializer #(
  parameter int ENTRY_NUM      = 4,
  parameter int ENTRY_BIT_SIZE = 4,
  parameter int READ_NUM       = 2
) (
  input logic clk,
  input logic rst,
  block_ram_scan_serializer_if.master bus
);
  localparam int INDEX_BIT_SIZE = $clog2(ENTRY_NUM);
  localparam int G              = READ_NUM * ENTRY_BIT_SIZE;
  localparam int CNT_W          = $clog2(G + 1);
  // one extra bit so base + READ_NUM can reach ENTRY_NUM without wrapping
  localparam int BASE_W         = INDEX_BIT_SIZE + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                    state, state_nxt;
  logic [BASE_W-1:0]         base;
  logic [BASE_W-1:0]         base_grp;
  logic [CNT_W-1:0]          bitcnt;
  logic [G-1:0]              shifter;
  logic [G-1:0]              rv_flat;
  logic                      parity;
  logic [INDEX_BIT_SIZE-1:0] ra_q [READ_NUM];
  logic                      hs;
  logic                      last_bit;
  logic                      last_group;

  assign base_grp   = base + BASE_W'(READ_NUM);
  assign last_group = (base_grp == BASE_W'(ENTRY_NUM));
  assign last_bit   = (bitcnt == CNT_W'(G));
  assign hs         = (state == S_SHIFT) && bus.oready;

  // pack the read ports with port 0 in the least significant bits
  always_comb begin
    rv_flat = '0;
    for (int i = 0; i < READ_NUM; i++) begin
      rv_flat[i*ENTRY_BIT_SIZE +: ENTRY_BIT_SIZE] = bus.rv[i];
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.start) state_nxt = S_READ;
      S_READ:    state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_SHIFT;
      S_SHIFT:   if (hs && last_bit) state_nxt = last_group ? S_DONE : S_READ;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // datapath: group base, read addresses, shifter, parity and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      base    <= '0;
      bitcnt  <= '0;
      shifter <= '0;
      parity  <= 1'b0;
      for (int i = 0; i < READ_NUM; i++) ra_q[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            base <= '0;
            for (int i = 0; i < READ_NUM; i++) ra_q[i] <= INDEX_BIT_SIZE'(i);
          end
        end
        S_CAPTURE: begin
          shifter <= rv_flat;
          parity  <= ^rv_flat;
          bitcnt  <= '0;
        end
        S_SHIFT: begin
          if (hs) begin
            if (!last_bit) begin
              shifter <= shifter >> 1;
              bitcnt  <= bitcnt + 1'b1;
            end else if (!last_group) begin
              // addresses for the next group are ready as READ begins
              base <= base_grp;
              for (int i = 0; i < READ_NUM; i++) begin
                ra_q[i] <= INDEX_BIT_SIZE'(base_grp + BASE_W'(i));
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // outputs decode from registers only, so oready never reaches obit/ovalid
  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.ovalid = (state == S_SHIFT);
  assign bus.obit   = (state == S_SHIFT) ? (last_bit ? parity : shifter[0]) : 1'b0;
  assign bus.ra     = ra_q;

endmodule

// File: tb/tb_block_ram_scan_serializer.sv
// Bench for block_ram_scan_serializer: a stream model built from the RAM
// contents checks every cycle, and literal tables pin the cycle timing.
module tb_block_ram_scan_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  block_ram_scan_serializer_if #(.ENTRY_NUM(4), .ENTRY_BIT_SIZE(4), .READ_NUM(2)) ifa ();
  block_ram_scan_serializer_if #(.ENTRY_NUM(4), .ENTRY_BIT_SIZE(4), .READ_NUM(1)) ifb ();

  block_ram_scan_serializer #(.ENTRY_NUM(4), .ENTRY_BIT_SIZE(4), .READ_NUM(2)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  block_ram_scan_serializer #(.ENTRY_NUM(4), .ENTRY_BIT_SIZE(4), .READ_NUM(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  logic [3:0] ram_a [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
  logic [3:0] ram_b [4] = '{4'hF, 4'hF, 4'hF, 4'hF};

  // RAM read ports, one-cycle latency
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) ifa.rv[i] <= ram_a[ifa.ra[i]];
    ifb.rv[0] <= ram_b[ifb.ra[0]];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- stream model for instance A ----------------
  bit expq[$];
  bit model_busy = 0;
  bit done_next = 0;
  bit chk_en = 0;

  function automatic void push_stream_a();
    bit par;
    bit bt;
    for (int base = 0; base < 4; base += 2) begin
      par = 0;
      for (int i = 0; i < 2; i++)
        for (int b = 0; b < 4; b++) begin
          bt = ram_a[base+i][b];
          expq.push_back(bt);
          par ^= bt;
        end
      expq.push_back(par);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) begin
        expq.delete();
        model_busy = 0;
        done_next = 0;
      end else begin
        check("busy", int'(ifa.busy), int'(model_busy));
        check("done", int'(ifa.done), int'(done_next));
        if (ifa.ovalid) begin
          if (expq.size() == 0) check("ovalid_unexpected", int'(ifa.ovalid), 0);
          else check("obit", int'(ifa.obit), int'(expq[0]));
        end
        if (ifa.start && !model_busy) begin
          push_stream_a();
          model_busy = 1;
        end
        if (done_next) begin
          model_busy = 0;
          done_next = 0;
        end
        if (ifa.ovalid && ifa.oready && expq.size() > 0) begin
          void'(expq.pop_front());
          if (expq.size() == 0) done_next = 1;
        end
      end
    end
  end

  // ---------------- per-sweep logs ----------------
  int base_a = 0;
  int hs_cyc[$], hs_bit[$], done_rel[$];
  int ra0_log[128], ra1_log[128], ov_log[128], busy_log[128], obit_log[128];
  int hsb_cyc[$], hsb_bit[$], doneb_rel[$];

  always @(negedge clk) begin
    int rel;
    rel = cyc - base_a;
    if (!rst && ifa.ovalid && ifa.oready) begin
      hs_cyc.push_back(rel);
      hs_bit.push_back(int'(ifa.obit));
    end
    if (ifa.done) done_rel.push_back(rel);
    if (rel >= 0 && rel < 128) begin
      ra0_log[rel]  = int'(ifa.ra[0]);
      ra1_log[rel]  = int'(ifa.ra[1]);
      ov_log[rel]   = int'(ifa.ovalid);
      busy_log[rel] = int'(ifa.busy);
      obit_log[rel] = int'(ifa.obit);
    end
    if (!rst && ifb.ovalid && ifb.oready) begin
      hsb_cyc.push_back(rel);
      hsb_bit.push_back(int'(ifb.obit));
    end
    if (ifb.done) doneb_rel.push_back(rel);
  end

  int exp_bits1 [18] = '{1,0,0,0,0,1,0,0,0, 1,1,0,0,0,0,1,0,1};

  task automatic clear_logs();
    hs_cyc.delete(); hs_bit.delete(); done_rel.delete();
    hsb_cyc.delete(); hsb_bit.delete(); doneb_rel.delete();
    for (int i = 0; i < 128; i++) begin
      ra0_log[i] = -1; ra1_log[i] = -1; ov_log[i] = -1; busy_log[i] = -1; obit_log[i] = -1;
    end
  endtask

  // mode 0 plain, 1 oready toggling, 2 extra start pulses, 3 reset at 8, 4 long stall
  task automatic run_a(input int mode);
    clear_logs();
    base_a = cyc;
    for (int rel = 0; rel < 400; rel++) begin
      if (mode == 3 && rel == 14) break;
      if (done_rel.size() > 0 && rel >= done_rel[0] + 2) break;
      ifa.start  = (rel == 0) || (mode == 2 && (rel == 5 || rel == 15));
      ifa.oready = (mode == 1) ? (rel % 2 == 0) :
                   (mode == 4) ? !(rel >= 3 && rel <= 52) : 1'b1;
      rst = (mode == 3 && rel == 8);
      @(posedge clk); #1;
    end
    ifa.start = 0; ifa.oready = 1; rst = 0;
    if (mode != 3) check("sweep_done_count", done_rel.size(), 1);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_beats"}, hs_bit.size(), 18);
    for (int i = 0; i < 18 && i < hs_bit.size(); i++)
      check({tag, "_bit"}, hs_bit[i], exp_bits1[i]);
  endtask

  initial begin
    ifa.start = 0; ifa.oready = 1;
    ifb.start = 0; ifb.oready = 1;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(ifa.busy), 0);
    check("rst_done", int'(ifa.done), 0);
    check("rst_ovalid", int'(ifa.ovalid), 0);
    check("rst_obit", int'(ifa.obit), 0);
    check("rst_ra0", int'(ifa.ra[0]), 0);
    check("rst_ra1", int'(ifa.ra[1]), 0);
    rst = 0;
    chk_en = 1;
    @(posedge clk); #1;

    // plain sweep, literal timing
    run_a(0);
    check_stream("t1");
    for (int i = 0; i < 18 && i < hs_cyc.size(); i++)
      check("t1_beat_cycle", hs_cyc[i], (i < 9) ? 3 + i : 5 + i);
    if (done_rel.size() > 0) check("t1_done_cycle", done_rel[0], 23);
    check("t1_ra0_c1", ra0_log[1], 0);
    check("t1_ra1_c1", ra1_log[1], 1);
    check("t1_ra0_c12", ra0_log[12], 2);
    check("t1_ra1_c12", ra1_log[12], 3);
    check("t1_ovalid_c2", ov_log[2], 0);
    check("t1_ovalid_gap12", ov_log[12], 0);
    check("t1_ovalid_gap13", ov_log[13], 0);
    check("t1_busy_c0", busy_log[0], 0);
    check("t1_busy_c1", busy_log[1], 1);
    check("t1_busy_c24", busy_log[24], 0);
    repeat (2) @(posedge clk); #1;

    // toggling backpressure
    run_a(1);
    check_stream("t2");
    repeat (2) @(posedge clk); #1;

    // start pulses while busy are ignored
    run_a(2);
    check_stream("t3");
    if (done_rel.size() > 0) check("t3_done_cycle", done_rel[0], 23);
    repeat (2) @(posedge clk); #1;

    // reset mid-sweep
    run_a(3);
    check("t4_ovalid_c9", ov_log[9], 0);
    check("t4_busy_c9", busy_log[9], 0);
    check("t4_ra0_c9", ra0_log[9], 0);
    check("t4_ra1_c9", ra1_log[9], 0);
    check("t4_no_done", done_rel.size(), 0);
    check("t4_partial_beats", hs_bit.size(), 5);
    repeat (2) @(posedge clk); #1;
    run_a(0);
    check_stream("t4_restart");
    repeat (2) @(posedge clk); #1;

    // long stall on the first beat
    run_a(4);
    for (int rel = 3; rel <= 52; rel++) begin
      check("t6_stall_ovalid", ov_log[rel], 1);
      check("t6_stall_obit", obit_log[rel], 1);
    end
    check_stream("t6");
    repeat (2) @(posedge clk); #1;

    // single read port, all-ones RAM
    clear_logs();
    base_a = cyc;
    for (int rel = 0; rel < 200; rel++) begin
      if (doneb_rel.size() > 0 && rel >= doneb_rel[0] + 2) break;
      ifb.start = (rel == 0);
      @(posedge clk); #1;
    end
    ifb.start = 0;
    check("t5_done_count", doneb_rel.size(), 1);
    if (doneb_rel.size() > 0) check("t5_done_cycle", doneb_rel[0], 29);
    check("t5_beats", hsb_bit.size(), 20);
    for (int i = 0; i < 20 && i < hsb_bit.size(); i++) begin
      check("t5_bit", hsb_bit[i], (i % 5 == 4) ? 0 : 1);
      check("t5_beat_cycle", hsb_cyc[i], 3 + 7 * (i / 5) + (i % 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/block_ram_scan_serializer.md
# block_ram_scan_serializer

Sweeps every entry of a multi-port block RAM through its READ_NUM read ports and emits the contents as a single-bit serial stream with a valid/ready handshake. It is the transmit-side counterpart of the serial-in test harness that loads RAM port inputs from one bit, and it lets a board-level or bench-level checker dump RAM contents over one pin. It sits between the RAM read ports (`ra`/`rv`) and an off-block serial sink.

## Interface
- ENTRY_NUM, 4, RAM entries; must be a multiple of READ_NUM
- ENTRY_BIT_SIZE, 4, bits per entry
- READ_NUM, 2, RAM read ports used in parallel
- INDEX_BIT_SIZE, $clog2(ENTRY_NUM), derived; not overridden
- clk  input  1  single clock, all logic on posedge
- rst  input  1  reset; synchronous, active-high (fixed)
- start  input  1  request a full sweep; sampled only in IDLE
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the final bit's handshake
- ra  output  INDEX_BIT_SIZE x READ_NUM (unpacked)  read addresses to RAM
- rv  input  ENTRY_BIT_SIZE x READ_NUM (unpacked)  read data, one-cycle latency after ra
- obit  output  1  serial data bit
- ovalid  output  1  obit valid
- oready  input  1  sink accepts obit this cycle

## Operation
- G = READ_NUM*ENTRY_BIT_SIZE bits per group; one group = entries base..base+READ_NUM-1.
- States: IDLE, READ, CAPTURE, SHIFT, DONE.
- IDLE: ovalid=0, busy=0. start=1 -> base=0, go READ. start=0 -> stay.
- READ (1 cycle): ra[i] = base+i for all i. -> CAPTURE.
- CAPTURE (1 cycle): ra held; at the clock edge load shifter = {rv[READ_NUM-1], ..., rv[0]} (rv[0] in LSBs), parity = XOR of all G bits, bitcnt=0. -> SHIFT.
- SHIFT: ovalid=1; obit = shifter[0] while bitcnt<G, obit = parity when bitcnt==G. On ovalid&&oready: shift right by 1, bitcnt++. Handshake on bitcnt==G ends the group: if base+READ_NUM==ENTRY_NUM -> DONE, else base+=READ_NUM -> READ.
- Stream per group: G data bits LSB-first, then 1 even-parity bit (G+1 beats).
- DONE (1 cycle): done=1, ovalid=0 -> IDLE.
- ra outside READ/CAPTURE holds its last value.
- start while busy: ignored, no queueing.
- base arithmetic INDEX_BIT_SIZE+1 bits wide so ENTRY_NUM compare never wraps.

## Timing
- Reset values: busy=0, done=0, ovalid=0, obit=0, all ra=0, state IDLE, base=0, bitcnt=0.
- rst mid-sweep: next cycle all outputs at reset values; partial stream abandoned, no done.
- start sampled at cycle N edge -> READ in N+1, CAPTURE in N+2, first beat valid in N+3.
- Per group with oready held 1: 2 + (G+1) cycles; group-to-group gap: 2 cycles ovalid=0.
- ovalid stays 1 and obit stable until oready=1; no bit dropped or repeated under backpressure.
- oready ignored when ovalid=0.
- done high exactly one cycle, the cycle after the last parity-bit handshake; busy falls with it (IDLE next).
- All outputs registered; no combinational path from oready to obit/ovalid.

## Test plan
- Defaults, RAM = {0x1,0x2,0x3,0x4}, start at cycle 0, oready=1 -> ra={0,1} in cycle 1; beats cycles 3-11 = 1,0,0,0,0,1,0,0,0; ra={2,3} cycle 12; beats 14-22 = 1,1,0,0,0,0,1,0,1; done=1 cycle 23 only.
- Same RAM, oready toggling 1,0,1,0… -> identical 18-bit sequence, obit constant across every oready=0 cycle, done delayed accordingly.
- start pulsed again at cycles 5 and 15 during a sweep -> no effect; exactly one done, stream unchanged.
- rst asserted in cycle 8 of the first test -> cycle 9: ovalid=0, busy=0, ra={0,0}; later start yields full stream from entry 0.
- RAM all 0xF, READ_NUM=1, ENTRY_NUM=4 -> 4 groups of 1,1,1,1,0 (parity 0), 2-cycle gaps, done after beat 20.
- oready=0 held 50 cycles at first beat then released -> obit=1, ovalid=1 throughout; stream resumes with no loss.
